// File: rtl/sba_pkg.sv
// Shared types and constants for the SBA interconnect and its decode block.
package sba_pkg;
    localparam int DW = 32;
    localparam int BW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } sba_state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // A single-slave build still needs a 1-bit select index.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sba_decode.sv
// Address-to-slave decode: picks the select field and flags indices
// that have no slave behind them.
module sba_decode
    import sba_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_HI   = 31,
    parameter int SEL_LO   = 28,
    parameter int IW       = sel_width(N_SLAVES)
) (
    input  logic [DW-1:0] addr,
    output logic [IW-1:0] sel,
    output logic          valid
);
    localparam int FW = SEL_HI - SEL_LO + 1;
    localparam logic [31:0] N_U = 32'(N_SLAVES);

    logic [FW-1:0] field;
    logic          unused_addr;

    assign field       = addr[SEL_HI:SEL_LO];
    assign unused_addr = ^addr;
    assign sel         = IW'(field);
    assign valid       = (32'(field) < N_U);
endmodule

// File: rtl/sba_interconnect.sv
// SBA interconnect: one master to N_SLAVES slaves with a registered request,
// decode-error and ack-timeout responses, and a sticky first-error capture.
module sba_interconnect
    import sba_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int SEL_HI   = 31,
    parameter int SEL_LO   = 28,
    parameter int TIMEOUT  = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [DW-1:0]          i_m_addr,
    input  logic                   i_m_stb,
    input  logic [BW-1:0]          i_m_we,
    input  logic [DW-1:0]          i_m_dat_w,
    output logic [DW-1:0]          o_m_dat_r,
    output logic                   o_m_ack,
    output logic                   o_m_err,
    output logic [DW-1:0]          o_s_addr,
    output logic [BW-1:0]          o_s_we,
    output logic [DW-1:0]          o_s_dat_w,
    output logic [N_SLAVES-1:0]    o_s_stb,
    input  logic [N_SLAVES-1:0]    i_s_ack,
    input  logic [DW*N_SLAVES-1:0] i_s_dat_r,
    output logic                   o_err_valid,
    output logic [DW-1:0]          o_err_addr,
    output logic [1:0]             o_err_cause,
    input  logic                   i_err_clr
);
    // state   | meaning
    // ST_IDLE | waiting for i_m_stb; request latched and decoded
    // ST_BUSY | strobing the selected slave, counting toward TIMEOUT
    // ST_RESP | one-cycle o_m_ack / o_m_err to the master

    localparam int IW = sel_width(N_SLAVES);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
    localparam bit TO_EN = (TIMEOUT != 0);

    sba_state_e    state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [DW-1:0] addr_q, addr_d, dat_w_q, dat_w_d, dat_r_q, dat_r_d;
    logic [BW-1:0] we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic          err_valid_q, err_valid_d;
    logic [DW-1:0] err_addr_q, err_addr_d;
    logic [1:0]    err_cause_q, err_cause_d;

    logic [IW-1:0]       dec_sel;
    logic                dec_valid;
    logic                sel_ack;
    logic [DW-1:0]       sel_dat;
    logic [1:0]          cause_new;
    logic [DW-1:0]       addr_new;
    logic [N_SLAVES-1:0] stb_c;

    sba_decode #(
        .N_SLAVES (N_SLAVES),
        .SEL_HI   (SEL_HI),
        .SEL_LO   (SEL_LO),
        .IW       (IW)
    ) u_decode (
        .addr  (i_m_addr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    assign sel_ack = i_s_ack[sel_q];
    assign sel_dat = i_s_dat_r[DW*sel_q +: DW];

    // Strobe drops in the ack cycle itself so the slave accepts exactly once.
    always_comb begin
        stb_c = '0;
        if (state_q == ST_BUSY && !sel_ack) stb_c[sel_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        we_d        = we_q;
        dat_w_d     = dat_w_q;
        dat_r_d     = dat_r_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        cause_new   = ERR_NONE;
        addr_new    = addr_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;

        case (state_q)
            ST_IDLE: begin
                if (i_m_stb) begin
                    addr_d  = i_m_addr;
                    we_d    = i_m_we;
                    dat_w_d = i_m_dat_w;
                    if (dec_valid) begin
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d   = ST_RESP;
                        err_d     = 1'b1;
                        dat_r_d   = '0;
                        cause_new = ERR_DECODE;
                        addr_new  = i_m_addr;
                    end
                end
            end
            ST_BUSY: begin
                if (sel_ack) begin
                    dat_r_d = sel_dat;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN && cnt_q == TO_VAL) begin
                    dat_r_d   = '0;
                    err_d     = 1'b1;
                    cause_new = ERR_TIMEOUT;
                    state_d   = ST_RESP;
                end else if (cnt_q != TO_VAL) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A new error in the clear cycle replaces the old capture.
        if (err_d && (!err_valid_q || i_err_clr)) begin
            err_valid_d = 1'b1;
            err_addr_d  = addr_new;
            err_cause_d = cause_new;
        end else if (i_err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
            err_cause_d = ERR_NONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            we_q        <= '0;
            dat_w_q     <= '0;
            dat_r_q     <= '0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            dat_w_q     <= dat_w_d;
            dat_r_q     <= dat_r_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign o_s_stb     = stb_c;
    assign o_s_addr    = addr_q;
    assign o_s_we      = we_q;
    assign o_s_dat_w   = dat_w_q;
    assign o_m_dat_r   = dat_r_q;
    assign o_m_ack     = ack_q;
    assign o_m_err     = err_q;
    assign o_err_valid = err_valid_q;
    assign o_err_addr  = err_addr_q;
    assign o_err_cause = err_cause_q;
endmodule

// File: tb/tb_sba_interconnect.sv
// Randomised scoreboard bench for sba_interconnect: slave models with
// configurable ack latency plus ack noise, checked against a transaction model.
module tb_sba_interconnect;
    localparam int N  = 4;
    localparam int TO = 8;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] dat;
        bit          chk_dat;
        int          lat;
        int          stb_cyc;
        logic        ev;
        logic [31:0] ea;
        logic [1:0]  ec;
        int          t0;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     m_addr = '0;
    logic            m_stb = 1'b0;
    logic [3:0]      m_we = '0;
    logic [31:0]     m_dat_w = '0;
    logic [31:0]     m_dat_r;
    logic            m_ack, m_err;
    logic [31:0]     s_addr, s_dat_w;
    logic [3:0]      s_we;
    logic [N-1:0]    s_stb, s_ack, mack, noise;
    logic [32*N-1:0] s_dat_r;
    logic            err_valid;
    logic [31:0]     err_addr;
    logic [1:0]      err_cause;
    logic            err_clr = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          resp_cnt = 0;
    int          stb_cyc = 0;
    bit          stb_bad = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          lat [N];
    bit          hold [N];
    int          stb_run [N];
    int          ack_left [N];
    logic [31:0] sdat [N];
    logic [N-1:0] nmask = '1;
    logic [N-1:0] cur_mask = '0;
    logic [31:0] cur_addr = '0, cur_dat = '0;
    logic [3:0]  cur_we = '0;
    bit          mv = 1'b0;
    logic [31:0] ma = '0;
    logic [1:0]  mc = '0;

    sba_interconnect #(
        .N_SLAVES (N),
        .SEL_HI   (31),
        .SEL_LO   (28),
        .TIMEOUT  (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_m_addr    (m_addr),
        .i_m_stb     (m_stb),
        .i_m_we      (m_we),
        .i_m_dat_w   (m_dat_w),
        .o_m_dat_r   (m_dat_r),
        .o_m_ack     (m_ack),
        .o_m_err     (m_err),
        .o_s_addr    (s_addr),
        .o_s_we      (s_we),
        .o_s_dat_w   (s_dat_w),
        .o_s_stb     (s_stb),
        .i_s_ack     (s_ack),
        .i_s_dat_r   (s_dat_r),
        .o_err_valid (err_valid),
        .o_err_addr  (err_addr),
        .o_err_cause (err_cause),
        .i_err_clr   (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dat
        assign s_dat_r[32*g +: 32] = sdat[g];
    end
    assign s_ack = mack | noise;

    // Slave k acks lat[k] cycles after first seeing its strobe (0 = never);
    // with hold[k] the ack lingers one extra cycle into the response phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mack  <= '0;
            noise <= '0;
            for (int k = 0; k < N; k++) begin
                stb_run[k]  = 0;
                ack_left[k] = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (s_stb[k]) begin
                    stb_run[k]++;
                    if (lat[k] != 0 && stb_run[k] == lat[k]) ack_left[k] = hold[k] ? 2 : 1;
                end else begin
                    stb_run[k] = 0;
                end
                mack[k] <= (ack_left[k] > 0);
                if (ack_left[k] > 0) ack_left[k]--;
            end
            noise <= N'($urandom) & nmask;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_stb != '0) begin
                stb_cyc++;
                if (s_stb !== cur_mask || s_addr !== cur_addr || s_we !== cur_we || s_dat_w !== cur_dat)
                    stb_bad = 1'b1;
            end
            if (m_ack || m_err) begin
                chk("resp_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_kind", {m_err, m_ack}, mon_e.kind);
                    if (mon_e.chk_dat) chk("rdata", m_dat_r, mon_e.dat);
                    chk("latency", 128'(cyc - mon_e.t0), 128'(mon_e.lat));
                    chk("stb_cycles", 128'(stb_cyc), 128'(mon_e.stb_cyc));
                    chk("stb_route", 128'(stb_bad), 128'(0));
                    chk("err_valid", err_valid, mon_e.ev);
                    chk("err_addr", err_addr, mon_e.ea);
                    chk("err_cause", err_cause, mon_e.ec);
                end
                stb_cyc  = 0;
                stb_bad  = 1'b0;
                resp_cnt++;
            end
        end
    end

    task automatic do_txn(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                          input int l, input bit h, input bit clr, input logic [31:0] rd);
        exp_t e;
        int   sel;
        int   start;
        sel = int'(addr[31:28]);
        @(posedge clk);
        #1;
        if (sel < N) begin
            lat[sel]  = l;
            hold[sel] = h;
            sdat[sel] = rd;
        end
        m_addr   = addr;
        m_we     = we;
        m_dat_w  = wd;
        m_stb    = 1'b1;
        err_clr  = clr;
        cur_addr = addr;
        cur_we   = we;
        cur_dat  = wd;
        cur_mask = (sel < N) ? N'(1 << sel) : '0;
        nmask    = ~cur_mask;

        if (clr) begin
            mv = 1'b0;
            ma = '0;
            mc = 2'd0;
        end
        e.chk_dat = 1'b1;
        e.dat     = '0;
        if (sel >= N) begin
            e.kind = 2'b10; e.lat = 1; e.stb_cyc = 0; e.chk_dat = 1'b0; e.ec = 2'd1;
        end else if (l != 0 && l <= TO) begin
            e.kind = 2'b01; e.lat = l + 2; e.stb_cyc = l; e.dat = rd; e.ec = 2'd0;
        end else begin
            e.kind = 2'b10; e.lat = TO + 2; e.stb_cyc = TO + 1; e.ec = 2'd2;
        end
        if (e.kind == 2'b10 && !mv) begin
            mv = 1'b1;
            ma = addr;
            mc = e.ec;
        end
        e.ev = mv;
        e.ea = ma;
        e.ec = mc;
        e.t0 = cyc;
        exp_q.push_back(e);
        start = resp_cnt;

        @(posedge clk);
        #1;
        err_clr = 1'b0;
        for (int i = 0; i < 40 && resp_cnt == start; i++) begin
            @(negedge clk);
            #1;
        end
        chk("resp_count", 128'(resp_cnt - start), 128'(1));
        if (resp_cnt == start) exp_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            m_stb = 1'b0;
        end
    endtask

    task automatic clr_idle();
        @(posedge clk);
        #1;
        m_stb   = 1'b0;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        mv = 1'b0;
        ma = '0;
        mc = 2'd0;
        chk("clr_valid", err_valid, mv);
        chk("clr_capture", {err_addr, err_cause}, {ma, mc});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_stb"}, s_stb, '0);
        chk({tag, "_resp"}, {m_ack, m_err}, '0);
        chk({tag, "_slave_bus"}, {s_addr, s_we, s_dat_w}, '0);
        chk({tag, "_rdata"}, m_dat_r, '0);
        chk({tag, "_err_regs"}, {err_valid, err_addr, err_cause}, '0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        lat[1]   = 0;
        hold[1]  = 1'b0;
        m_addr   = 32'h1000_0100;
        m_we     = 4'b0;
        m_stb    = 1'b1;
        cur_addr = m_addr;
        cur_we   = 4'b0;
        cur_dat  = m_dat_w;
        cur_mask = 4'b0010;
        nmask    = ~cur_mask;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_stb", s_stb, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        m_stb = 1'b0;
        exp_q.delete();
        mv = 1'b0;
        ma = '0;
        mc = 2'd0;
        stb_cyc = 0;
        stb_bad = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            lat[k]  = 1;
            hold[k] = 1'b0;
            sdat[k] = '0;
        end
        #12;
        chk_reset("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        do_txn(32'h1000_0010, 4'b0000, 32'h0,          1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_txn(32'h2000_0040, 4'b0011, 32'h1234_5678,  1, 1'b0, 1'b0, 32'h0BAD_F00D);
        idle(2);
        do_txn(32'h5000_0000, 4'b1111, 32'hFFFF_FFFF,  1, 1'b0, 1'b0, 32'h0);
        do_txn(32'h3000_0008, 4'b0000, 32'h0,          0, 1'b0, 1'b0, 32'h1111_2222);
        clr_idle();
        do_txn(32'h0000_0ABC, 4'b0000, 32'h0,         TO, 1'b1, 1'b0, 32'h7777_0001);
        do_txn(32'h1000_0020, 4'b0000, 32'h0,     TO + 1, 1'b1, 1'b0, 32'h3333_4444);
        do_txn(32'h7000_0004, 4'b0001, 32'h55,         1, 1'b0, 1'b1, 32'h0);
        idle(1);

        repeat (70) begin
            logic [31:0] a;
            logic [3:0]  w;
            int          l;
            a = {4'($urandom_range(0, 5)), 28'($urandom)};
            if ($urandom_range(0, 9) == 0) a[31:28] = 4'hF;
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 2);
            do_txn(a, w, $urandom, l, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) clr_idle();
        end

        do_txn(32'h2000_0000, 4'b0000, 32'h0, 1, 1'b0, 1'b0, 32'hCAFE_0001);
        do_txn(32'h9000_0000, 4'b0000, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        do_txn(32'h2000_0004, 4'b0000, 32'h0, 2, 1'b0, 1'b0, 32'hCAFE_0002);
        idle(1);
        mid_reset();
        do_txn(32'h1000_0010, 4'b0000, 32'h0, 1, 1'b0, 1'b0, 32'hA5A5_5A5A);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/sba_interconnect.md
# sba_interconnect

Parametrised SBA (Simple Bus Architecture) interconnect between one bus master (the OR32 CPU) and N_SLAVES memory-mapped slaves; successor to the hard-wired four-region address decode/mux in `soc`. It registers each request, decodes the slave from a configurable address-bit field, and forwards the strobe to exactly one slave. It returns data with a single-cycle ack and adds what the fixed mux lacks: a decode-error response, a per-transaction ack timeout, and a sticky error-capture register.

## Interface
- N_SLAVES, 4, number of slave ports (1..16)
- SEL_HI, 31, top bit of the slave-select field in address
- SEL_LO, 28, bottom bit of the slave-select field
- TIMEOUT, 255, cycles in BUSY without ack before error; 0 disables timeout
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_m_addr  in  32  master address
- i_m_stb  in  1  master strobe; held with addr/we/dat_w stable until o_m_ack or o_m_err
- i_m_we  in  4  byte write enables (0 = read)
- i_m_dat_w  in  32  write data
- o_m_dat_r  out  32  read data, valid with o_m_ack
- o_m_ack  out  1  one-cycle completion pulse
- o_m_err  out  1  one-cycle error completion pulse (decode or timeout)
- o_s_addr  out  32  registered address to all slaves
- o_s_we  out  4  registered byte enables to all slaves
- o_s_dat_w  out  32  registered write data to all slaves
- o_s_stb  out  N_SLAVES  one-hot slave strobe
- i_s_ack  in  N_SLAVES  slave acks
- i_s_dat_r  in  32*N_SLAVES  slave read data, slave k at [32k+31:32k]
- o_err_valid  out  1  sticky: an error has been captured
- o_err_addr  out  32  address of first captured error
- o_err_cause  out  2  0 none, 1 decode, 2 timeout
- i_err_clr  in  1  clears error-capture registers

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: when i_m_stb=1, latch addr/we/dat_w into o_s_*. Decode sel = addr[SEL_HI:SEL_LO].
  - If sel < N_SLAVES, latch sel and go to BUSY. Clear the timeout counter.
  - Otherwise go to RESP with err. No slave strobe is issued.
- BUSY: o_s_stb[sel] = ~i_s_ack[sel]. The strobe is combinational from the registered state, so it drops in the ack cycle and a slave sees exactly one accepted write.
  - On i_s_ack[sel]: capture i_s_dat_r[sel] into o_m_dat_r and go to RESP (ack).
  - Acks from non-selected slaves are ignored.
- Timeout: the counter increments each BUSY cycle. When it reaches TIMEOUT with no ack, go to RESP (err) with o_m_dat_r = 0. Ack and timeout in the same cycle: ack wins.
- RESP: assert o_m_ack or o_m_err for exactly one cycle, then go to IDLE. All slave acks are ignored in RESP and IDLE.
- Error capture: on the first error while o_err_valid=0, load o_err_addr and o_err_cause and set o_err_valid. Later errors do not overwrite the capture. i_err_clr clears it; a simultaneous new error wins over clear.
- Writes on a decode error have no side effect.

## Timing
- Reset (async assert, sync deassert):
  - State IDLE.
  - o_s_stb, o_m_ack, o_m_err, o_err_valid = 0.
  - o_s_addr, o_s_we, o_s_dat_w, o_m_dat_r, o_err_addr, o_err_cause = 0.
  - Counter = 0.
- Reset mid-transaction aborts it immediately; o_s_stb drops asynchronously.
- Latency:
  - stb sampled at cycle t0 → o_s_stb at t1.
  - A slave acking one cycle after strobe (BRAM/ROM style) → ack at t2 → o_m_ack at t3.
  - Decode error → o_m_err at t1.
  - Timeout → o_m_err at t1+TIMEOUT+1.
- The master may issue its next request in the cycle after o_m_ack/o_m_err. Back-to-back throughput is one transaction per 4 cycles with 1-cycle slaves.
- The counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.

## Structure
- Package sba_pkg:
  - State enum (IDLE/BUSY/RESP).
  - Error cause constants (ERR_NONE=0, ERR_DECODE=1, ERR_TIMEOUT=2).
  - Data width 32 and byte-enable width 4 constants.
- Sub-module sba_decode: combinational, address → sel index + valid, parametrised by SEL_HI/SEL_LO/N_SLAVES. Reused by future multi-master arbiters.

## Test plan
- Read slave 1 (addr 0x1000_0010; slave acks 1 cycle after stb with 0xDEADBEEF) → o_s_stb=4'b0010 for exactly 1 cycle, o_m_ack at t3, o_m_dat_r=0xDEADBEEF.
- Write we=4'b0011, data 0x1234_5678 to slave 2 → o_s_we/o_s_dat_w match, slave sees stb high exactly 1 cycle, o_m_ack, o_m_err=0.
- Addr 0x5000_0000 with N_SLAVES=4 → no o_s_stb, o_m_err at t1, o_err_valid=1, o_err_cause=1, o_err_addr=0x5000_0000.
- TIMEOUT=8, slave 3 never acks → o_s_stb[3] high 9 cycles, o_m_err, cause=2. A second error leaves the capture unchanged; i_err_clr → o_err_valid=0.
- Slave acks in the exact cycle the counter hits TIMEOUT → o_m_ack, no o_m_err. Stale ack in RESP/IDLE → no extra o_m_ack.
- i_rst_n low during BUSY → o_s_stb=0 immediately, all outputs 0. After release, the next read completes normally.
